bnn_layer_engine: RTL and testbench
===================================

Name: bnn_layer_engine

Overview:
- Parametrised successor to the single-bit XNOR/popcount compute module.
- Evaluates one fully-connected binarised layer per start command and reads LANES weight and activation bits per cycle.
- Each output neuron is either written back to activation memory as a thresholded bit or, in final mode, fed into a running argmax.
- A higher-level sequencer issues one command per layer: layer sizes and memory bank selects are runtime inputs, not hardwired states.

Parameters:
- LANES, 8, bits per memory word and XNOR/popcount width (power of 2, 1..64).
- ACC_W, 12, accumulator and length width; must hold the maximum in_len.
- W_ADDR_LEN, 20, weight word-address width.
- X_ADDR_LEN, 10, activation address width (word address on reads, bit address on writes).
- SEL_LEN, 2, memory bank select width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  command strobe; accepted only in IDLE.
- cfg_in_len  in  ACC_W  inputs per neuron.
- cfg_out_len  in  ACC_W  neurons in layer.
- cfg_w_sel  in  SEL_LEN  weight bank.
- cfg_x_rd_sel  in  SEL_LEN  source activation bank.
- cfg_x_wr_sel  in  SEL_LEN  destination activation bank.
- cfg_final  in  1  1 = argmax mode, no writeback.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  one-cycle pulse; command rejected.
- w_rd_en  out  1  weight read strobe.
- w_addr  out  W_ADDR_LEN  weight word address.
- w_sel  out  SEL_LEN  weight bank select.
- w_data  in  LANES  weight word, valid 1 cycle after w_rd_en.
- x_rd_en  out  1  activation read strobe.
- x_rd_addr  out  X_ADDR_LEN  activation word address.
- x_rd_sel  out  SEL_LEN  activation read bank.
- x_data  in  LANES  activation word, valid 1 cycle after x_rd_en.
- x_wr_en  out  1  activation bit write strobe.
- x_wr_addr  out  X_ADDR_LEN  bit address (neuron index).
- x_wr_sel  out  SEL_LEN  activation write bank.
- x_wr_data  out  1  activated neuron bit.
- result_valid  out  1  high from final-mode done until next accepted start.
- result_idx  out  ACC_W  argmax neuron index.
- result_score  out  ACC_W  argmax popcount.

Behaviour:
- Reset (rst=0, any time, including mid-layer):
  - State returns to IDLE and all counters and the accumulator clear.
  - Every output is 0.
  - No memory strobe is asserted while rst=0 or on the first edge after release.
- Command acceptance:
  - start in IDLE latches all cfg_* inputs.
  - start outside IDLE is ignored.
  - Command is rejected if cfg_in_len==0, cfg_out_len==0, or cfg_in_len mod LANES != 0.
  - On rejection: cfg_err pulses the next cycle, state stays IDLE, busy stays 0.
- Derived quantities: W = in_len/LANES words per neuron; n = neuron index; k = word index.
- States: IDLE -> FETCH -> DRAIN -> WRITE -> (FETCH if n < out_len-1, else DONE) -> IDLE.
  - FETCH (W cycles):
    - w_rd_en=1, w_addr = n*W + k.
    - x_rd_en=1, x_rd_addr = k.
    - k = 0..W-1.
  - Accumulate on the edge after each read: acc += popcount(~(w_data ^ x_data)).
    - acc clears at entry to FETCH for each neuron.
  - DRAIN (1 cycle): absorbs the last returning word; no strobes.
  - WRITE (1 cycle), cfg_final=0:
    - x_wr_en=1, x_wr_addr = n, x_wr_data = (2*acc >= in_len).
  - WRITE (1 cycle), cfg_final=1:
    - No write.
    - If n==0 or acc > best_score, update best_idx=n and best_score=acc.
    - Ties keep the lower index.
  - DONE (1 cycle):
    - done=1, busy=0 from the next edge.
    - In final mode, result_idx/score are loaded and result_valid=1.
- busy=1 in FETCH, DRAIN, WRITE and DONE.
- Latency from accepted start to done pulse: out_len*(W+2)+1 cycles.
- The 2*acc comparison uses ACC_W+1 bits; no overflow permitted.
- w_addr is computed with a running base register (base += W per neuron), not a multiplier; it wraps modulo 2^W_ADDR_LEN with no error.
- result_valid clears on the next accepted (non-rejected) start; result fields hold their values until then.

Decomposition:
- Shared package bnn_pkg:
  - State encoding constants (ST_IDLE..ST_DONE).
  - Bank select constants BANK_L1..BANK_L4 (0..3).
  - Default LANES and ACC_W.
- One sub-module, bnn_xnor_popcount:
  - Combinational, LANES-wide XNOR plus adder tree.
  - Output width $clog2(LANES)+1.

Test Plan:
- LANES=8, in_len=16, out_len=2, final=0, all w_data=x_data=8'hFF:
  - Neurons write x_wr_data=1 at addresses 0 and 1.
  - done comes 2*(2+2)+1 = 9 cycles after start.
- in_len=16, out_len=1, w_data=8'h0F, x_data=8'hFF (acc=8):
  - 2*8 >= 16, so x_wr_data=1.
  - With w_data=8'h07 (acc=6), x_wr_data=0.
- Final mode, out_len=4, per-neuron scores 5,9,9,3:
  - result_idx=1, result_score=9, result_valid=1 (tie resolves to lower index).
- start with cfg_in_len=12 (LANES=8), then cfg_out_len=0:
  - cfg_err pulses each time; busy, done and the memory strobes stay 0.
- start pulsed again while busy:
  - Ignored; the original layer completes with an unchanged done latency.
- rst driven low in the 3rd FETCH cycle of neuron 1:
  - All outputs are 0 asynchronously.
  - After release, a new command runs correctly from neuron 0 with acc cleared.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the binarised layer engine.
// Holds FSM state encoding, bank select names and default widths.
package bnn_pkg;

    localparam int LANES_DEF = 8;
    localparam int ACC_W_DEF = 12;

    localparam logic [1:0] BANK_L1 = 2'd0;
    localparam logic [1:0] BANK_L2 = 2'd1;
    localparam logic [1:0] BANK_L3 = 2'd2;
    localparam logic [1:0] BANK_L4 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational LANES-wide XNOR followed by a population count.
// Ports: w_i, x_i (LANES bits) -> cnt_o (number of matching bits).
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    localparam int PW = $clog2(LANES) + 1
) (
    input  logic [LANES-1:0] w_i,
    input  logic [LANES-1:0] x_i,
    output logic [PW-1:0]    cnt_o
);

    logic [LANES-1:0] match;

    assign match = ~(w_i ^ x_i);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < LANES; i++) begin
            cnt_o = cnt_o + PW'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_layer_engine.sv
// One fully-connected binarised layer per command: XNOR/popcount per neuron,
// then thresholded writeback or running argmax (final mode).
// Ports: clk/rst, start + cfg_* command, busy/done/cfg_err status,
// weight and activation read ports (1-cycle latency), activation bit
// write port, and result_valid/idx/score for final-mode layers.
module bnn_layer_engine
    import bnn_pkg::*;
#(
    parameter int LANES      = LANES_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int W_ADDR_LEN = 20,
    parameter int X_ADDR_LEN = 10,
    parameter int SEL_LEN    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ACC_W-1:0]      cfg_in_len,
    input  logic [ACC_W-1:0]      cfg_out_len,
    input  logic [SEL_LEN-1:0]    cfg_w_sel,
    input  logic [SEL_LEN-1:0]    cfg_x_rd_sel,
    input  logic [SEL_LEN-1:0]    cfg_x_wr_sel,
    input  logic                  cfg_final,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  w_rd_en,
    output logic [W_ADDR_LEN-1:0] w_addr,
    output logic [SEL_LEN-1:0]    w_sel,
    input  logic [LANES-1:0]      w_data,
    output logic                  x_rd_en,
    output logic [X_ADDR_LEN-1:0] x_rd_addr,
    output logic [SEL_LEN-1:0]    x_rd_sel,
    input  logic [LANES-1:0]      x_data,
    output logic                  x_wr_en,
    output logic [X_ADDR_LEN-1:0] x_wr_addr,
    output logic [SEL_LEN-1:0]    x_wr_sel,
    output logic                  x_wr_data,
    output logic                  result_valid,
    output logic [ACC_W-1:0]      result_idx,
    output logic [ACC_W-1:0]      result_score
);

    localparam int LOG2L = $clog2(LANES);
    localparam int PW    = LOG2L + 1;
    localparam logic [ACC_W-1:0] LMASK = ACC_W'(LANES - 1);

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    in_len_q, in_len_d;
    logic [ACC_W-1:0]    out_len_q, out_len_d;
    logic [ACC_W-1:0]    words_q, words_d;
    logic [SEL_LEN-1:0]  w_sel_q, w_sel_d;
    logic [SEL_LEN-1:0]  xr_sel_q, xr_sel_d;
    logic [SEL_LEN-1:0]  xw_sel_q, xw_sel_d;
    logic                final_q, final_d;
    logic [ACC_W-1:0]    k_q, k_d;
    logic [ACC_W-1:0]    n_q, n_d;
    logic [W_ADDR_LEN-1:0] base_q, base_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                rd_q, rd_d;
    logic [ACC_W-1:0]    best_idx_q, best_idx_d;
    logic [ACC_W-1:0]    best_sc_q, best_sc_d;
    logic [ACC_W-1:0]    res_idx_q, res_idx_d;
    logic [ACC_W-1:0]    res_sc_q, res_sc_d;
    logic                res_vld_q, res_vld_d;
    logic                err_q, err_d;

    logic [PW-1:0]       pop;
    logic                cfg_bad;
    logic                thr;

    bnn_xnor_popcount #(.LANES(LANES)) u_pop (
        .w_i   (w_data),
        .x_i   (x_data),
        .cnt_o (pop)
    );

    assign cfg_bad = (cfg_in_len == '0) || (cfg_out_len == '0) ||
                     ((cfg_in_len & LMASK) != '0);

    // One extra bit so 2*acc cannot wrap before the compare.
    assign thr = {acc_q, 1'b0} >= {1'b0, in_len_q};

    always_comb begin
        state_d    = state_q;
        in_len_d   = in_len_q;
        out_len_d  = out_len_q;
        words_d    = words_q;
        w_sel_d    = w_sel_q;
        xr_sel_d   = xr_sel_q;
        xw_sel_d   = xw_sel_q;
        final_d    = final_q;
        k_d        = k_q;
        n_d        = n_q;
        base_d     = base_q;
        acc_d      = acc_q;
        rd_d       = 1'b0;
        best_idx_d = best_idx_q;
        best_sc_d  = best_sc_q;
        res_idx_d  = res_idx_q;
        res_sc_d   = res_sc_q;
        res_vld_d  = res_vld_q;
        err_d      = 1'b0;
        w_rd_en    = 1'b0;
        x_rd_en    = 1'b0;
        x_wr_en    = 1'b0;
        done       = 1'b0;

        // Read data returns one cycle after the strobe.
        if (rd_q) begin
            acc_d = acc_q + ACC_W'(pop);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        in_len_d  = cfg_in_len;
                        out_len_d = cfg_out_len;
                        words_d   = cfg_in_len >> LOG2L;
                        w_sel_d   = cfg_w_sel;
                        xr_sel_d  = cfg_x_rd_sel;
                        xw_sel_d  = cfg_x_wr_sel;
                        final_d   = cfg_final;
                        k_d       = '0;
                        n_d       = '0;
                        base_d    = '0;
                        acc_d     = '0;
                        res_vld_d = 1'b0;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                w_rd_en = 1'b1;
                x_rd_en = 1'b1;
                rd_d    = 1'b1;
                if (k_q == words_q - ACC_W'(1)) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + ACC_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                x_wr_en = !final_q;
                // Strict > keeps the lower index on ties.
                if (final_q && (n_q == '0 || acc_q > best_sc_q)) begin
                    best_idx_d = n_q;
                    best_sc_d  = acc_q;
                end
                if (n_q == out_len_q - ACC_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    n_d     = n_q + ACC_W'(1);
                    base_d  = base_q + W_ADDR_LEN'(words_q);
                    acc_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (final_q) begin
                    res_idx_d = best_idx_q;
                    res_sc_d  = best_sc_q;
                    res_vld_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            in_len_q   <= '0;
            out_len_q  <= '0;
            words_q    <= '0;
            w_sel_q    <= '0;
            xr_sel_q   <= '0;
            xw_sel_q   <= '0;
            final_q    <= 1'b0;
            k_q        <= '0;
            n_q        <= '0;
            base_q     <= '0;
            acc_q      <= '0;
            rd_q       <= 1'b0;
            best_idx_q <= '0;
            best_sc_q  <= '0;
            res_idx_q  <= '0;
            res_sc_q   <= '0;
            res_vld_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_len_q   <= in_len_d;
            out_len_q  <= out_len_d;
            words_q    <= words_d;
            w_sel_q    <= w_sel_d;
            xr_sel_q   <= xr_sel_d;
            xw_sel_q   <= xw_sel_d;
            final_q    <= final_d;
            k_q        <= k_d;
            n_q        <= n_d;
            base_q     <= base_d;
            acc_q      <= acc_d;
            rd_q       <= rd_d;
            best_idx_q <= best_idx_d;
            best_sc_q  <= best_sc_d;
            res_idx_q  <= res_idx_d;
            res_sc_q   <= res_sc_d;
            res_vld_q  <= res_vld_d;
            err_q      <= err_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign cfg_err      = err_q;
    assign w_addr       = base_q + W_ADDR_LEN'(k_q);
    assign w_sel        = w_sel_q;
    assign x_rd_addr    = X_ADDR_LEN'(k_q);
    assign x_rd_sel     = xr_sel_q;
    assign x_wr_addr    = X_ADDR_LEN'(n_q);
    assign x_wr_sel     = xw_sel_q;
    assign x_wr_data    = x_wr_en & thr;
    assign result_valid = res_vld_q;
    assign result_idx   = res_idx_q;
    assign result_score = res_sc_q;

endmodule

// File: tb/tb_bnn_layer_engine.sv
// Directed self-checking bench for bnn_layer_engine (LANES=8).
// Memories are modelled with one-cycle read latency.
module tb_bnn_layer_engine;

    localparam int LANES = 8;
    localparam int ACC_W = 12;
    localparam int WA    = 20;
    localparam int XA    = 10;
    localparam int SL    = 2;
    localparam int OW    = 8 + WA + SL + XA + SL + XA + SL + 2 * ACC_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [ACC_W-1:0] cfg_in_len = '0;
    logic [ACC_W-1:0] cfg_out_len = '0;
    logic [SL-1:0] cfg_w_sel = '0;
    logic [SL-1:0] cfg_x_rd_sel = '0;
    logic [SL-1:0] cfg_x_wr_sel = '0;
    logic cfg_final = 1'b0;
    logic busy, done, cfg_err;
    logic w_rd_en, x_rd_en, x_wr_en, x_wr_data;
    logic [WA-1:0] w_addr;
    logic [SL-1:0] w_sel, x_rd_sel, x_wr_sel;
    logic [LANES-1:0] w_data = '0;
    logic [LANES-1:0] x_data = '0;
    logic [XA-1:0] x_rd_addr, x_wr_addr;
    logic result_valid;
    logic [ACC_W-1:0] result_idx, result_score;
    logic [OW-1:0] all_out;

    bnn_layer_engine #(
        .LANES(LANES), .ACC_W(ACC_W), .W_ADDR_LEN(WA),
        .X_ADDR_LEN(XA), .SEL_LEN(SL)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len),
        .cfg_w_sel(cfg_w_sel), .cfg_x_rd_sel(cfg_x_rd_sel),
        .cfg_x_wr_sel(cfg_x_wr_sel), .cfg_final(cfg_final),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_sel(w_sel),
        .w_data(w_data), .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr),
        .x_rd_sel(x_rd_sel), .x_data(x_data), .x_wr_en(x_wr_en),
        .x_wr_addr(x_wr_addr), .x_wr_sel(x_wr_sel),
        .x_wr_data(x_wr_data), .result_valid(result_valid),
        .result_idx(result_idx), .result_score(result_score)
    );

    assign all_out = {busy, done, cfg_err, w_rd_en, x_rd_en, x_wr_en,
                      x_wr_data, result_valid, w_addr, w_sel, x_rd_addr,
                      x_rd_sel, x_wr_addr, x_wr_sel, result_idx,
                      result_score};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] wmem [16];
    logic [7:0] xmem [16];

    always @(posedge clk) begin
        w_data <= wmem[w_addr[3:0]];
        x_data <= xmem[x_rd_addr[3:0]];
    end

    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;
    int done_cyc = 0, err_cyc = 0;
    logic [XA-1:0] wr_addr_log [64];
    logic          wr_data_log [64];
    logic [SL-1:0] wr_sel_log  [64];
    logic [WA-1:0] wa_log      [64];
    logic [XA-1:0] xa_log      [64];
    logic [2*SL-1:0] rs_log    [64];

    always @(negedge clk) begin
        if (rst) begin
            if (x_wr_en) begin
                wr_addr_log[wr_cnt % 64] <= x_wr_addr;
                wr_data_log[wr_cnt % 64] <= x_wr_data;
                wr_sel_log[wr_cnt % 64]  <= x_wr_sel;
                wr_cnt <= wr_cnt + 1;
            end
            if (w_rd_en || x_rd_en) begin
                wa_log[rd_cnt % 64] <= w_addr;
                xa_log[rd_cnt % 64] <= x_rd_addr;
                rs_log[rd_cnt % 64] <= {w_sel, x_rd_sel};
                rd_cnt <= rd_cnt + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (cfg_err) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
            if (busy) busy_cnt <= busy_cnt + 1;
        end
    end

    int checks = 0;
    int fails = 0;
    int start_cyc = 0;

    task automatic issue(input int il, input int ol, input logic [1:0] ws,
                         input logic [1:0] xr, input logic [1:0] xw,
                         input logic fin);
        @(negedge clk);
        cfg_in_len   = ACC_W'(il);
        cfg_out_len  = ACC_W'(ol);
        cfg_w_sel    = ws;
        cfg_x_rd_sel = xr;
        cfg_x_wr_sel = xw;
        cfg_final    = fin;
        start        = 1'b1;
        start_cyc    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_cnt != base) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic fill(input logic [7:0] wv, input logic [7:0] xv);
        for (int i = 0; i < 16; i++) begin
            wmem[i] = wv;
            xmem[i] = xv;
        end
    endtask

    task automatic test_reset;
        fill(8'hFF, 8'hFF);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, need 0", all_out);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, w_rd_en, x_rd_en, x_wr_en, result_valid} !== 5'b0) begin
            fails++;
            $display("FAIL reset_release: busy/strobes/valid=%b, need 0",
                     {busy, w_rd_en, x_rd_en, x_wr_en, result_valid});
        end
    endtask

    task automatic test_all_ones;
        int bw, br, bd;
        bit ok;
        fill(8'hFF, 8'hFF);
        bw = wr_cnt; br = rd_cnt; bd = done_cnt;
        issue(16, 2, 2'd1, 2'd2, 2'd3, 1'b0);
        wait_done(bd, ok);
        @(negedge clk);
        #1;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL ones_timeout: no done pulse, need one");
        end
        checks++;
        if (done_cyc - start_cyc !== 9) begin
            fails++;
            $display("FAIL ones_latency: got %0d, need 9",
                     done_cyc - start_cyc);
        end
        checks++;
        if (wr_cnt - bw !== 2) begin
            fails++;
            $display("FAIL ones_wr_count: got %0d, need 2", wr_cnt - bw);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({wr_addr_log[(bw+i)%64], wr_data_log[(bw+i)%64],
                 wr_sel_log[(bw+i)%64]} !== {XA'(i), 1'b1, 2'd3}) begin
                fails++;
                $display("FAIL ones_write%0d: addr %0d data %b sel %0d, need %0d 1 3",
                         i, wr_addr_log[(bw+i)%64], wr_data_log[(bw+i)%64],
                         wr_sel_log[(bw+i)%64], i);
            end
        end
        checks++;
        if (rd_cnt - br !== 4) begin
            fails++;
            $display("FAIL ones_rd_count: got %0d, need 4", rd_cnt - br);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({wa_log[(br+i)%64], xa_log[(br+i)%64], rs_log[(br+i)%64]}
                !== {WA'(i), XA'(i % 2), 4'b0110}) begin
                fails++;
                $display("FAIL ones_read%0d: w_addr %0d x_addr %0d sel %b, need %0d %0d 0110",
                         i, wa_log[(br+i)%64], xa_log[(br+i)%64],
                         rs_log[(br+i)%64], i, i % 2);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL ones_idle: busy %b, need 0", busy);
        end
    endtask

    task automatic test_threshold;
        int bw, bd;
        bit ok;
        logic [7:0] wv [2];
        logic exp_bit [2];
        wv[0] = 8'h0F; exp_bit[0] = 1'b1;
        wv[1] = 8'h07; exp_bit[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            fill(wv[t], 8'hFF);
            bw = wr_cnt; bd = done_cnt;
            issue(16, 1, 2'd0, 2'd0, 2'd0, 1'b0);
            wait_done(bd, ok);
            @(negedge clk);
            #1;
            checks++;
            if (!ok || done_cyc - start_cyc !== 5) begin
                fails++;
                $display("FAIL thr%0d_latency: done seen %b after %0d, need 5",
                         t, ok, done_cyc - start_cyc);
            end
            checks++;
            if (wr_cnt - bw !== 1 || wr_data_log[bw%64] !== exp_bit[t]) begin
                fails++;
                $display("FAIL thr%0d_bit: %0d writes, bit %b, need 1 write bit %b",
                         t, wr_cnt - bw, wr_data_log[bw%64], exp_bit[t]);
            end
        end
    endtask

    task automatic test_final;
        int bw, br, bd;
        bit ok;
        fill(8'h00, 8'hFF);
        wmem[0] = 8'h1F; wmem[1] = 8'h00;
        wmem[2] = 8'hFF; wmem[3] = 8'h01;
        wmem[4] = 8'h01; wmem[5] = 8'hFF;
        wmem[6] = 8'h07; wmem[7] = 8'h00;
        bw = wr_cnt; br = rd_cnt; bd = done_cnt;
        issue(16, 4, 2'd0, 2'd0, 2'd0, 1'b1);
        wait_done(bd, ok);
        @(negedge clk);
        #1;
        checks++;
        if (!ok || done_cyc - start_cyc !== 17) begin
            fails++;
            $display("FAIL final_latency: done seen %b after %0d, need 17",
                     ok, done_cyc - start_cyc);
        end
        checks++;
        if ({result_valid, result_idx, result_score}
            !== {1'b1, ACC_W'(1), ACC_W'(9)}) begin
            fails++;
            $display("FAIL final_result: valid %b idx %0d score %0d, need 1 1 9",
                     result_valid, result_idx, result_score);
        end
        checks++;
        if (wr_cnt != bw) begin
            fails++;
            $display("FAIL final_no_write: %0d writes, need 0", wr_cnt - bw);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (wa_log[(br+i)%64] !== WA'(i)) begin
                fails++;
                $display("FAIL final_waddr%0d: got %0d, need %0d",
                         i, wa_log[(br+i)%64], i);
            end
        end
    endtask

    task automatic test_reject;
        int be, bb, br, bd, bw;
        int il [2];
        int ol [2];
        il[0] = 12; ol[0] = 1;
        il[1] = 16; ol[1] = 0;
        for (int t = 0; t < 2; t++) begin
            be = err_cnt; bb = busy_cnt; br = rd_cnt;
            bd = done_cnt; bw = wr_cnt;
            issue(il[t], ol[t], 2'd0, 2'd0, 2'd0, 1'b0);
            repeat (3) @(negedge clk);
            #1;
            checks++;
            if (err_cnt - be !== 1 || err_cyc - start_cyc !== 1) begin
                fails++;
                $display("FAIL rej%0d_err: %0d pulses at +%0d, need 1 at +1",
                         t, err_cnt - be, err_cyc - start_cyc);
            end
            checks++;
            if (busy_cnt != bb || rd_cnt != br || done_cnt != bd ||
                wr_cnt != bw) begin
                fails++;
                $display("FAIL rej%0d_quiet: busy %0d rd %0d done %0d wr %0d, need all 0",
                         t, busy_cnt - bb, rd_cnt - br, done_cnt - bd,
                         wr_cnt - bw);
            end
            checks++;
            if (result_valid !== 1'b1) begin
                fails++;
                $display("FAIL rej%0d_valid_kept: got %b, need 1",
                         t, result_valid);
            end
        end
    endtask

    task automatic test_back_to_back;
        int bw, bd, bb;
        fill(8'hFF, 8'hFF);
        bw = wr_cnt; bd = done_cnt; bb = busy_cnt;
        issue(16, 2, 2'd0, 2'd0, 2'd0, 1'b0);
        #1;
        checks++;
        if (result_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_valid_clear: got %b, need 0", result_valid);
        end
        cfg_in_len = ACC_W'(8);
        cfg_out_len = ACC_W'(1);
        cfg_final = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && cyc != start_cyc + 9; i++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        checks++;
        if (done_cnt - bd !== 1 || done_cyc - start_cyc !== 9) begin
            fails++;
            $display("FAIL b2b_done: %0d pulses, last at +%0d, need 1 at +9",
                     done_cnt - bd, done_cyc - start_cyc);
        end
        checks++;
        if (busy_cnt - bb !== 9 || wr_cnt - bw !== 2) begin
            fails++;
            $display("FAIL b2b_work: busy %0d cycles, %0d writes, need 9 and 2",
                     busy_cnt - bb, wr_cnt - bw);
        end
        checks++;
        if (result_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ignored: result_valid %b, need 0", result_valid);
        end
    endtask

    task automatic test_reset_mid;
        int br, bd;
        bit ok;
        fill(8'hFF, 8'hFF);
        issue(32, 2, 2'd2, 2'd1, 2'd3, 1'b0);
        for (int i = 0; i < 20 && cyc != start_cyc + 9; i++) @(negedge clk);
        #1;
        checks++;
        if ({w_rd_en, w_addr, w_sel} !== {1'b1, WA'(6), 2'd2}) begin
            fails++;
            $display("FAIL mid_fetch: rd %b addr %0d sel %0d, need 1 6 2",
                     w_rd_en, w_addr, w_sel);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL mid_async_reset: got %h, need 0", all_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        br = rd_cnt;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rd_cnt != br || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_release: %0d reads busy %b, need 0 0",
                     rd_cnt - br, busy);
        end
        fill(8'h07, 8'hFF);
        bd = done_cnt;
        issue(16, 1, 2'd0, 2'd0, 2'd0, 1'b1);
        wait_done(bd, ok);
        @(negedge clk);
        #1;
        checks++;
        if (!ok || done_cyc - start_cyc !== 5) begin
            fails++;
            $display("FAIL mid_rerun_latency: done seen %b after %0d, need 5",
                     ok, done_cyc - start_cyc);
        end
        checks++;
        if ({result_valid, result_idx, result_score}
            !== {1'b1, ACC_W'(0), ACC_W'(6)}) begin
            fails++;
            $display("FAIL mid_rerun_result: valid %b idx %0d score %0d, need 1 0 6",
                     result_valid, result_idx, result_score);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_threshold();
        test_final();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
